// File: rtl/apa102_frame_decoder_pkg.sv
// Shared types and constants for the APA102 serial frame decoder.
package apa102_frame_decoder_pkg;

  typedef enum logic [1:0] {
    StSeek,
    StPixel,
    StTrail
  } state_e;

  // Zero bits that mark a start frame (and close a trail).
  localparam int unsigned START_ZEROS = 32;
  // Bits per LED word.
  localparam int unsigned WORD_BITS   = 32;
  // Top three bits of every LED word.
  localparam logic [2:0]  HEADER      = 3'b111;

endpackage

// File: rtl/apa102_frame_decoder_edge.sv
// Input registers for the serial bus plus rise/fall strobes of led_clk.
module led_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic led_clk,
  input  logic led_data,
  output logic data_bit,
  output logic rise,
  output logic fall
);

  logic clk_q, data_q, clk_prev_q;

  // Align led_clk/led_data in one stage, keep a second led_clk stage for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_q      <= 1'b0;
      data_q     <= 1'b0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_q      <= led_clk;
      data_q     <= led_data;
      clk_prev_q <= clk_q;
    end
  end

  assign rise     = clk_q & ~clk_prev_q;
  assign fall     = ~clk_q & clk_prev_q;
  assign data_bit = data_q;

endmodule

// File: rtl/apa102_frame_decoder.sv
// Decodes an APA102 bit stream into per-pixel brightness/colour words.
module apa102_frame_decoder
  import apa102_frame_decoder_pkg::*;
#(
  parameter int unsigned N_PIXELS = 64,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_clk,
  input  logic       led_data,
  output logic       pix_valid,
  output logic [5:0] pix_idx,
  output logic [4:0] pix_bright,
  output logic [7:0] pix_b,
  output logic [7:0] pix_g,
  output logic [7:0] pix_r,
  output logic       frame_done,
  output logic       err_header,
  output logic       err_timeout,
  output logic [7:0] frame_count
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT);
  localparam logic [5:0]       ZeroSat  = 6'(START_ZEROS);
  localparam logic [5:0]       ZeroLast = 6'(START_ZEROS - 1);
  localparam logic [4:0]       LastBit  = 5'(WORD_BITS - 1);
  localparam logic [5:0]       LastIdx  = 6'(N_PIXELS - 1);

  logic data_bit, rise, fall;

  led_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .led_clk  (led_clk),
    .led_data (led_data),
    .data_bit (data_bit),
    .rise     (rise),
    .fall     (fall)
  );

  state_e           state_q, state_d;
  logic [5:0]       zero_cnt_q, zero_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  // Only the 28 most recent bits are kept; the header is checked early.
  logic [27:0]      shift_q, shift_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [5:0]       idx_q, idx_d;
  logic [5:0]       pix_idx_q, pix_idx_d;
  logic [4:0]       bright_q, bright_d;
  logic [7:0]       b_q, b_d, g_q, g_d, r_q, r_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             valid_q, valid_d, done_q, done_d;
  logic             err_hdr_q, err_hdr_d, err_tmo_q, err_tmo_d;
  logic             header_bad, timeout_hit;

  // Next-state logic: error returns first, then one bit per falling edge.
  always_comb begin
    state_d       = state_q;
    zero_cnt_d    = zero_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    pix_idx_d     = pix_idx_q;
    bright_d      = bright_q;
    b_d           = b_q;
    g_d           = g_q;
    r_d           = r_q;
    frame_count_d = frame_count_q;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    err_hdr_d     = 1'b0;
    err_tmo_d     = 1'b0;
    idle_d        = '0;

    header_bad  = (state_q == StPixel) && fall && (bit_cnt_q == 5'd2) &&
                  ({shift_q[1:0], data_bit} != HEADER);
    timeout_hit = (state_q == StPixel) && (idle_q == IdleMax);

    if ((state_q == StPixel) && !(rise || fall)) idle_d = idle_q + 1'b1;

    if (header_bad || timeout_hit) begin
      // Header error wins; the edge of this cycle is dropped either way.
      err_hdr_d  = header_bad;
      err_tmo_d  = !header_bad;
      state_d    = StSeek;
      zero_cnt_d = '0;
      bit_cnt_d  = '0;
      idx_d      = '0;
      idle_d     = '0;
    end else if (fall) begin
      unique case (state_q)
        StSeek: begin
          if (!data_bit) begin
            if (zero_cnt_q != ZeroSat) zero_cnt_d = zero_cnt_q + 1'b1;
          end else if (zero_cnt_q == ZeroSat) begin
            state_d   = StPixel;
            shift_d   = {shift_q[26:0], data_bit};
            bit_cnt_d = 5'd1;
          end else begin
            zero_cnt_d = '0;
          end
        end
        StPixel: begin
          shift_d   = {shift_q[26:0], data_bit};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
            valid_d   = 1'b1;
            pix_idx_d = idx_q;
            bright_d  = shift_q[27:23];
            b_d       = shift_q[22:15];
            g_d       = shift_q[14:7];
            r_d       = {shift_q[6:0], data_bit};
            if (idx_q == LastIdx) begin
              done_d        = 1'b1;
              frame_count_d = frame_count_q + 8'd1;
              state_d       = StTrail;
              zero_cnt_d    = '0;
              idx_d         = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        StTrail: begin
          if (data_bit) begin
            zero_cnt_d = '0;
          end else if (zero_cnt_q == ZeroLast) begin
            zero_cnt_d = ZeroSat;
            state_d    = StSeek;
          end else begin
            zero_cnt_d = zero_cnt_q + 1'b1;
          end
        end
        default: state_d = StSeek;
      endcase
    end
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StSeek;
      zero_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      idle_q        <= '0;
      idx_q         <= '0;
      pix_idx_q     <= '0;
      bright_q      <= '0;
      b_q           <= '0;
      g_q           <= '0;
      r_q           <= '0;
      frame_count_q <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      err_hdr_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      zero_cnt_q    <= zero_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      idle_q        <= idle_d;
      idx_q         <= idx_d;
      pix_idx_q     <= pix_idx_d;
      bright_q      <= bright_d;
      b_q           <= b_d;
      g_q           <= g_d;
      r_q           <= r_d;
      frame_count_q <= frame_count_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      err_hdr_q     <= err_hdr_d;
      err_tmo_q     <= err_tmo_d;
    end
  end

  assign pix_valid   = valid_q;
  assign pix_idx     = pix_idx_q;
  assign pix_bright  = bright_q;
  assign pix_b       = b_q;
  assign pix_g       = g_q;
  assign pix_r       = r_q;
  assign frame_done  = done_q;
  assign err_header  = err_hdr_q;
  assign err_timeout = err_tmo_q;
  assign frame_count = frame_count_q;

endmodule
